lpc_target_arbiter: RTL
=======================

LPC_TARGET_ARBITER -- requirements
Module: lpc_target_arbiter

Interface
REQ-001 SHALL have parameter T0_BASE, default 16'h002E, target 0 I/O base address.
REQ-002 SHALL have parameter T0_MASK, default 16'hFFFE; target 0 hits when (addr & T0_MASK) == T0_BASE.
REQ-003 SHALL have parameter T1_BASE, default 16'h0080, target 1 I/O base address.
REQ-004 SHALL have parameter T1_MASK, default 16'hFFFF; target 1 hits when (addr & T1_MASK) == T1_BASE.
REQ-005 SHALL have parameter TIMEOUT, default 64, max cycles to wait for a target ack (range 2..255).
REQ-006 SHALL have parameters T0_IRQ default 4'd1 and T1_IRQ default 4'd12, the SERIRQ slot of each target.
REQ-007 SHALL have ports: clk_i input 1, LPC clock; nrst_i input 1, reset, asynchronous, active-low.
REQ-008 SHALL have ports: lpc_addr_i input 16, peripheral address; lpc_wdata_i input 8, write data; lpc_data_wr_i input 1, write pending (level); lpc_data_req_i input 1, read pending (level).
REQ-009 SHALL have ports: lpc_rdata_o output 8, read data; lpc_data_rd_o output 1, read data valid; lpc_wr_done_o output 1, write accepted.
REQ-010 SHALL have per target n in {0,1}: tn_req_o output 1; tn_we_o output 1; tn_addr_o output 16; tn_wdata_o output 8; tn_ack_i input 1 (one-cycle pulse); tn_rdata_i input 8, valid with ack; tn_irq_i input 1, level interrupt request.
REQ-011 SHALL have ports: irq_num_o output 4; interrupt_o output 1; err_o output 1, sticky error; err_clr_i input 1.

Function
REQ-012 All logic SHALL be posedge clk_i; inputs from the LPC peripheral are level signals and are sampled once per clock.
REQ-013 FSM states SHALL be IDLE, WR_WAIT, RD_WAIT, WR_DONE, RD_DONE.
REQ-014 In IDLE, lpc_data_wr_i=1 SHALL latch addr/wdata, decode, and go to WR_WAIT; the hit target's req_o and we_o are 1 on the next cycle.
REQ-015 In IDLE, lpc_data_req_i=1 with lpc_data_wr_i=0 SHALL latch addr and go to RD_WAIT with the hit target's req_o=1 and we_o=0; if both are 1, the write wins.
REQ-016 If both targets match, target 0 SHALL win; at most one tn_req_o is ever high.
REQ-017 tn_req_o, tn_we_o, tn_addr_o and tn_wdata_o SHALL stay stable until ack, timeout or abort; req_o drops in the cycle after ack.
REQ-018 Ack in WR_WAIT SHALL go to WR_DONE, with lpc_wr_done_o=1 from the next cycle until lpc_data_wr_i is sampled 0, then IDLE.
REQ-019 Ack in RD_WAIT SHALL latch tn_rdata_i into lpc_rdata_o and go to RD_DONE, with lpc_data_rd_o=1 from the next cycle until lpc_data_req_i is sampled 0, then IDLE.
REQ-020 An unmapped address SHALL skip the WAIT state: a write goes directly to WR_DONE, and a read goes to RD_DONE with lpc_rdata_o=8'hFF; err_o is unaffected.
REQ-021 A timeout counter SHALL clear on WAIT entry; when it reaches TIMEOUT-1 without ack, req_o drops, err_o is set, and the transaction completes as in REQ-020 (read data 8'hFF).
REQ-022 An ack arriving in the same cycle as the timeout SHALL take precedence (normal completion, no error).
REQ-023 If the pending level drops while in WR_WAIT/RD_WAIT (host abort), the FSM SHALL drop req_o and return to IDLE without asserting done/rd, and SHALL ignore acks outside WAIT states.
REQ-024 err_o SHALL clear on err_clr_i=1 unless a new error occurs in the same cycle, in which case the set wins.
REQ-025 interrupt_o SHALL be registered t0_irq_i | t1_irq_i (one-cycle latency).
REQ-026 irq_num_o SHALL be registered: T0_IRQ if t0_irq_i, else T1_IRQ if t1_irq_i, else its previous value.
REQ-027 lpc_rdata_o SHALL hold its value until the next read completes.

Reset
REQ-028 On nrst_i=0 the block SHALL asynchronously enter IDLE and clear all of the following: req, we, done, rd_o, err_o, interrupt_o, counter; lpc_rdata_o=8'hFF, irq_num_o=4'd0, tn_addr_o=0, tn_wdata_o=0.
REQ-029 A reset in the middle of a transaction SHALL abandon it; a target ack after reset is ignored.

Verification
REQ-030 Write: addr 16'h002F, data 8'h5A, t0 ack after 3 cycles -> t0_we_o=1, t0_wdata_o=8'h5A, lpc_wr_done_o=1 the cycle after ack, and it stays high until lpc_data_wr_i=0.
REQ-031 Read: addr 16'h0080, t1 ack with 8'hC3 -> lpc_rdata_o=8'hC3 and lpc_data_rd_o=1 the cycle after ack; t0_req_o stays 0 throughout.
REQ-032 Read of unmapped 16'h0400 -> no tn_req_o; lpc_data_rd_o=1 within 2 cycles with 8'hFF; err_o=0.
REQ-033 Read to t0 with no ack -> req drops after TIMEOUT cycles; rdata=8'hFF, err_o=1; err_clr_i pulse -> err_o=0.
REQ-034 lpc_data_wr_i drops in WR_WAIT -> IDLE, lpc_wr_done_o never asserted, a late t0_ack_i is ignored.
REQ-035 t1_irq_i=1 then t0_irq_i=1 -> irq_num_o goes 12 then 1, interrupt_o=1; both released -> interrupt_o=0, irq_num_o holds 1.

Source files
------------

// File: rtl/lpc_target_arbiter_if.sv
// LPC peripheral-side and target-side signal bundle for lpc_target_arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
`timescale 1ns/1ps
interface lpc_target_arbiter_if;
  logic [15:0] lpc_addr_i;
  logic [7:0]  lpc_wdata_i;
  logic        lpc_data_wr_i;
  logic        lpc_data_req_i;
  logic [7:0]  lpc_rdata_o;
  logic        lpc_data_rd_o;
  logic        lpc_wr_done_o;

  logic        t0_req_o;
  logic        t0_we_o;
  logic [15:0] t0_addr_o;
  logic [7:0]  t0_wdata_o;
  logic        t0_ack_i;
  logic [7:0]  t0_rdata_i;
  logic        t0_irq_i;

  logic        t1_req_o;
  logic        t1_we_o;
  logic [15:0] t1_addr_o;
  logic [7:0]  t1_wdata_o;
  logic        t1_ack_i;
  logic [7:0]  t1_rdata_i;
  logic        t1_irq_i;

  logic [3:0]  irq_num_o;
  logic        interrupt_o;
  logic        err_o;
  logic        err_clr_i;

  modport slave (
    input  lpc_addr_i, lpc_wdata_i, lpc_data_wr_i, lpc_data_req_i,
    output lpc_rdata_o, lpc_data_rd_o, lpc_wr_done_o,
    output t0_req_o, t0_we_o, t0_addr_o, t0_wdata_o,
    input  t0_ack_i, t0_rdata_i, t0_irq_i,
    output t1_req_o, t1_we_o, t1_addr_o, t1_wdata_o,
    input  t1_ack_i, t1_rdata_i, t1_irq_i,
    output irq_num_o, interrupt_o, err_o,
    input  err_clr_i
  );

  modport master (
    output lpc_addr_i, lpc_wdata_i, lpc_data_wr_i, lpc_data_req_i,
    input  lpc_rdata_o, lpc_data_rd_o, lpc_wr_done_o,
    input  t0_req_o, t0_we_o, t0_addr_o, t0_wdata_o,
    output t0_ack_i, t0_rdata_i, t0_irq_i,
    input  t1_req_o, t1_we_o, t1_addr_o, t1_wdata_o,
    output t1_ack_i, t1_rdata_i, t1_irq_i,
    input  irq_num_o, interrupt_o, err_o,
    output err_clr_i
  );
endinterface

// File: rtl/lpc_target_arbiter.sv
// Routes LPC I/O cycles to one of two decoded targets with ack timeout,
// host abort, sticky error flag and SERIRQ slot selection.
`timescale 1ns/1ps
module lpc_target_arbiter #(
  parameter logic [15:0] T0_BASE = 16'h002E,
  parameter logic [15:0] T0_MASK = 16'hFFFE,
  parameter logic [15:0] T1_BASE = 16'h0080,
  parameter logic [15:0] T1_MASK = 16'hFFFF,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [3:0]  T0_IRQ  = 4'd1,
  parameter logic [3:0]  T1_IRQ  = 4'd12
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  lpc_target_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned NT    = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    RD_WAIT = 3'd2,
    WR_DONE = 3'd3,
    RD_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [NT-1:0]     req_q, req_d;
  logic [NT-1:0]     we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              int_q, int_d;
  logic [3:0]        irq_num_q, irq_num_d;

  logic              hit0_c, hit1_c;
  logic [NT-1:0]     sel_c;
  logic              ack_c;
  logic [7:0]        tgt_rdata_c;
  logic              timeout_c;
  logic              err_set_c;

  // Address decode; target 0 has priority on overlap.
  assign hit0_c      = (bus.lpc_addr_i & T0_MASK) == T0_BASE;
  assign hit1_c      = (bus.lpc_addr_i & T1_MASK) == T1_BASE;
  assign sel_c       = {hit1_c & ~hit0_c, hit0_c};
  assign ack_c       = |(req_q & {bus.t1_ack_i, bus.t0_ack_i});
  assign tgt_rdata_c = req_q[1] ? bus.t1_rdata_i : bus.t0_rdata_i;
  assign timeout_c   = cnt_q == CNT_W'(TIMEOUT - 1);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = done_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    err_set_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.lpc_data_wr_i) begin
          addr_d  = bus.lpc_addr_i;
          wdata_d = bus.lpc_wdata_i;
          if (|sel_c) begin
            req_d   = sel_c;
            we_d    = sel_c;
            cnt_d   = '0;
            state_d = WR_WAIT;
          end else begin
            done_d  = 1'b1;
            state_d = WR_DONE;
          end
        end else if (bus.lpc_data_req_i) begin
          addr_d = bus.lpc_addr_i;
          if (|sel_c) begin
            req_d   = sel_c;
            we_d    = '0;
            cnt_d   = '0;
            state_d = RD_WAIT;
          end else begin
            rdata_d = 8'hFF;
            rd_d    = 1'b1;
            state_d = RD_DONE;
          end
        end
      end
      // Host abort beats ack; ack beats timeout.
      WR_WAIT: begin
        if (!bus.lpc_data_wr_i) begin
          req_d   = '0;
          we_d    = '0;
          state_d = IDLE;
        end else if (ack_c || timeout_c) begin
          err_set_c = ~ack_c;
          req_d     = '0;
          we_d      = '0;
          done_d    = 1'b1;
          state_d   = WR_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (!bus.lpc_data_req_i) begin
          req_d   = '0;
          we_d    = '0;
          state_d = IDLE;
        end else if (ack_c || timeout_c) begin
          err_set_c = ~ack_c;
          rdata_d   = ack_c ? tgt_rdata_c : 8'hFF;
          req_d     = '0;
          we_d      = '0;
          rd_d      = 1'b1;
          state_d   = RD_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_DONE: begin
        if (!bus.lpc_data_wr_i) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RD_DONE: begin
        if (!bus.lpc_data_req_i) begin
          rd_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = '0;
        we_d    = '0;
        done_d  = 1'b0;
        rd_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    err_d     = err_set_c | (err_q & ~bus.err_clr_i);
    int_d     = bus.t0_irq_i | bus.t1_irq_i;
    irq_num_d = bus.t0_irq_i ? T0_IRQ : (bus.t1_irq_i ? T1_IRQ : irq_num_q);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= 8'hFF;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      int_q     <= 1'b0;
      irq_num_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      int_q     <= int_d;
      irq_num_q <= irq_num_d;
    end
  end

  assign bus.lpc_rdata_o   = rdata_q;
  assign bus.lpc_data_rd_o = rd_q;
  assign bus.lpc_wr_done_o = done_q;
  assign bus.t0_req_o      = req_q[0];
  assign bus.t0_we_o       = we_q[0];
  assign bus.t0_addr_o     = addr_q;
  assign bus.t0_wdata_o    = wdata_q;
  assign bus.t1_req_o      = req_q[1];
  assign bus.t1_we_o       = we_q[1];
  assign bus.t1_addr_o     = addr_q;
  assign bus.t1_wdata_o    = wdata_q;
  assign bus.irq_num_o     = irq_num_q;
  assign bus.interrupt_o   = int_q;
  assign bus.err_o         = err_q;

endmodule
